// File: rtl/sat_accumulator3.sv
// sat_accumulator3: 3-bit saturating accumulator with ready/valid input, falling-edge state.
// Ports:
//   i_clk       clock; every state update happens on its falling edge
//   i_reset_n   asynchronous active-low reset
//   i_clear     synchronous clear of total, beat count and flags (beats that arrive with it are dropped)
//   i_in_valid  producer offers a beat on i_in_data
//   i_in_data   unsigned increment 0..7
//   o_in_ready  block accepts a beat this cycle (low only while saturated)
//   o_acc       registered running total
//   o_full      total is saturated at LIMIT
//   o_ovf       sticky: an accepted beat would have pushed the total past LIMIT
//   o_done      one-cycle pulse on entry to saturation
//   o_beats     accepted beats since the last clear, modulo 8
module sat_accumulator3 #(
    parameter int LIMIT = 7
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_clear,
    input  logic       i_in_valid,
    input  logic [2:0] i_in_data,
    output logic       o_in_ready,
    output logic [2:0] o_acc,
    output logic       o_full,
    output logic       o_ovf,
    output logic       o_done,
    output logic [2:0] o_beats
);
    typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;
    localparam logic [3:0] L4 = 4'(LIMIT);
    state_t     r_state, w_state;
    logic [2:0] r_acc, w_acc, r_beats, w_beats;
    logic       r_full, w_full, r_ovf, w_ovf, r_done, w_done;
    logic [3:0] w_sum;
    logic       w_accept;
    // 4-bit sum keeps the adder carry-out so totals of 8..14 still compare above LIMIT
    assign w_sum      = {1'b0, r_acc} + {1'b0, i_in_data};
    assign o_in_ready = r_state != FULL;
    assign w_accept   = i_in_valid && o_in_ready;
    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_beats <= '0;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_acc   <= w_acc;
            r_beats <= w_beats;
            r_full  <= w_full;
            r_ovf   <= w_ovf;
            r_done  <= w_done;
        end
    end
    // clear outranks a simultaneous accept, so that beat is neither added nor counted
    always_comb begin
        w_state = r_state;
        w_acc   = r_acc;
        w_beats = r_beats;
        w_full  = r_full;
        w_ovf   = r_ovf;
        w_done  = 1'b0;
        if (i_clear) begin
            w_state = IDLE;
            w_acc   = '0;
            w_beats = '0;
            w_full  = 1'b0;
            w_ovf   = 1'b0;
        end else if (w_accept) begin
            w_beats = r_beats + 3'd1;
            if (w_sum >= L4) begin
                w_state = FULL;
                w_acc   = L4[2:0];
                w_full  = 1'b1;
                w_done  = 1'b1;
                w_ovf   = r_ovf || (w_sum > L4);
            end else begin
                w_state = RUN;
                w_acc   = w_sum[2:0];
            end
        end
    end
    assign o_acc   = r_acc;
    assign o_beats = r_beats;
    assign o_full  = r_full;
    assign o_ovf   = r_ovf;
    assign o_done  = r_done;
endmodule

// File: tb/tb_sat_accumulator3.sv
// tb_sat_accumulator3: scoreboard bench for sat_accumulator3 at LIMIT=7 and LIMIT=4.
module tb_sat_accumulator3;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clear = 1'b0, in_valid = 1'b0;
    logic [2:0] in_data = '0;
    logic clear4 = 1'b0, in_valid4 = 1'b0;
    logic [2:0] in_data4 = '0;
    logic in_ready, full, ovf, done, in_ready4, full4, ovf4, done4;
    logic [2:0] acc, beats, acc4, beats4;
    int checks = 0;
    int failures = 0;
    logic [9:0] sb[$];
    logic [9:0] obs7, obs4;

    sat_accumulator3 #(.LIMIT(7)) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_clear(clear), .i_in_valid(in_valid),
        .i_in_data(in_data), .o_in_ready(in_ready), .o_acc(acc), .o_full(full),
        .o_ovf(ovf), .o_done(done), .o_beats(beats)
    );
    sat_accumulator3 #(.LIMIT(4)) dut4 (
        .i_clk(clk), .i_reset_n(reset_n), .i_clear(clear4), .i_in_valid(in_valid4),
        .i_in_data(in_data4), .o_in_ready(in_ready4), .o_acc(acc4), .o_full(full4),
        .o_ovf(ovf4), .o_done(done4), .o_beats(beats4)
    );

    always #5 clk = ~clk;
    assign obs7 = {in_ready, acc, full, ovf, done, beats};
    assign obs4 = {in_ready4, acc4, full4, ovf4, done4, beats4};

    // expected vector {ready, acc, full, ovf, done, beats}
    function automatic logic [9:0] pk(input logic r, input logic [2:0] a, input logic f,
                                      input logic o, input logic d, input logic [2:0] b);
        return {r, a, f, o, d, b};
    endfunction

    // drive one beat during clock-high, then wait past the falling edge; u4 selects the LIMIT=4 unit
    task automatic step(input bit u4, input logic [4:0] s);
        @(posedge clk);
        #1;
        in_valid  = u4 ? 1'b0 : s[4];
        in_data   = u4 ? 3'd0 : s[3:1];
        clear     = u4 ? 1'b0 : s[0];
        in_valid4 = u4 ? s[4] : 1'b0;
        in_data4  = u4 ? s[3:1] : 3'd0;
        clear4    = u4 ? s[0] : 1'b0;
        @(negedge clk);
        #1;
        in_valid = 1'b0; clear = 1'b0; in_valid4 = 1'b0; clear4 = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] e;
        #3;
        sb.push_back(pk(1, 0, 0, 0, 0, 0));
        sb.push_back(pk(1, 0, 0, 0, 0, 0));
        e = sb.pop_front();
        checks++;
        if (obs7 !== e) begin failures++; $display("FAIL reset7 got=%b exp=%b", obs7, e); end
        e = sb.pop_front();
        checks++;
        if (obs4 !== e) begin failures++; $display("FAIL reset4 got=%b exp=%b", obs4, e); end
        @(posedge clk);
        #2 reset_n = 1'b1;
    endtask

    task automatic test_accumulate();
        logic [4:0] st[2];
        logic [9:0] ex[2];
        logic [9:0] e;
        st = '{5'b1_010_0, 5'b1_011_0};
        ex = '{pk(1, 2, 0, 0, 0, 1), pk(1, 5, 0, 0, 0, 2)};
        for (int i = 0; i < 2; i++) begin
            sb.push_back(ex[i]);
            step(0, st[i]);
            e = sb.pop_front();
            checks++;
            if (obs7 !== e) begin failures++; $display("FAIL accumulate[%0d] got=%b exp=%b", i, obs7, e); end
        end
    endtask

    task automatic test_full_stall();
        logic [4:0] st[4];
        logic [9:0] ex[4];
        logic [9:0] e;
        st = '{5'b1_010_0, 5'b1_100_0, 5'b1_100_0, 5'b1_100_0};
        ex = '{pk(0, 7, 1, 0, 1, 3), pk(0, 7, 1, 0, 0, 3), pk(0, 7, 1, 0, 0, 3), pk(0, 7, 1, 0, 0, 3)};
        for (int i = 0; i < 4; i++) begin
            sb.push_back(ex[i]);
            step(0, st[i]);
            e = sb.pop_front();
            checks++;
            if (obs7 !== e) begin failures++; $display("FAIL full_stall[%0d] got=%b exp=%b", i, obs7, e); end
        end
    endtask

    task automatic test_overflow();
        logic [4:0] st[5];
        logic [9:0] ex[5];
        logic [9:0] e;
        st = '{5'b0_000_1, 5'b1_110_0, 5'b1_101_0, 5'b0_000_0, 5'b0_000_1};
        ex = '{pk(1, 0, 0, 0, 0, 0), pk(1, 6, 0, 0, 0, 1), pk(0, 7, 1, 1, 1, 2),
               pk(0, 7, 1, 1, 0, 2), pk(1, 0, 0, 0, 0, 0)};
        for (int i = 0; i < 5; i++) begin
            sb.push_back(ex[i]);
            step(0, st[i]);
            e = sb.pop_front();
            checks++;
            if (obs7 !== e) begin failures++; $display("FAIL overflow[%0d] got=%b exp=%b", i, obs7, e); end
        end
    endtask

    task automatic test_clear_priority();
        logic [4:0] st[3];
        logic [9:0] ex[3];
        logic [9:0] e;
        st = '{5'b1_100_0, 5'b1_011_1, 5'b0_000_0};
        ex = '{pk(1, 4, 0, 0, 0, 1), pk(1, 0, 0, 0, 0, 0), pk(1, 0, 0, 0, 0, 0)};
        for (int i = 0; i < 3; i++) begin
            sb.push_back(ex[i]);
            step(0, st[i]);
            e = sb.pop_front();
            checks++;
            if (obs7 !== e) begin failures++; $display("FAIL clear_priority[%0d] got=%b exp=%b", i, obs7, e); end
        end
    endtask

    task automatic test_limit4_wrap();
        logic [9:0] e;
        for (int i = 0; i < 4; i++)
            sb.push_back(pk(i == 3 ? 1'b0 : 1'b1, 3'(i + 1), i == 3, 1'b0, i == 3, 3'(i + 1)));
        sb.push_back(pk(0, 4, 1, 0, 0, 4));
        sb.push_back(pk(1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++)
            sb.push_back(pk(1, 0, 0, 0, 0, 3'((i + 1) % 8)));
        for (int i = 0; i < 14; i++) begin
            step(1, i < 4 ? 5'b1_001_0 : i == 4 ? 5'b1_001_0 : i == 5 ? 5'b0_000_1 : 5'b1_000_0);
            e = sb.pop_front();
            checks++;
            if (obs4 !== e) begin failures++; $display("FAIL limit4_wrap[%0d] got=%b exp=%b", i, obs4, e); end
        end
    endtask

    task automatic test_async_reset();
        logic [9:0] e;
        step(0, 5'b0_000_1);
        sb.push_back(pk(1, 3, 0, 0, 0, 1));
        step(0, 5'b1_011_0);
        e = sb.pop_front();
        checks++;
        if (obs7 !== e) begin failures++; $display("FAIL async_setup got=%b exp=%b", obs7, e); end
        @(posedge clk);
        #2 reset_n = 1'b0;
        sb.push_back(pk(1, 0, 0, 0, 0, 0));
        #1;
        e = sb.pop_front();
        checks++;
        if (obs7 !== e) begin failures++; $display("FAIL async_reset got=%b exp=%b", obs7, e); end
        #1 reset_n = 1'b1;
        in_valid = 1'b1;
        in_data  = 3'd6;
        sb.push_back(pk(1, 6, 0, 0, 0, 1));
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (obs7 !== e) begin failures++; $display("FAIL async_release got=%b exp=%b", obs7, e); end
    endtask

    initial begin
        test_reset();
        test_accumulate();
        test_full_stall();
        test_overflow();
        test_clear_priority();
        test_limit4_wrap();
        test_async_reset();
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sat_accumulator3.md
Name: sat_accumulator3

Overview:
3-bit saturating accumulator stage that sits directly downstream of the 3-bit carry-lookahead adder. It registers the adder's sum and feeds it back as the running total, adding accepted input beats. When the total reaches a programmable limit it saturates and stalls the producer until cleared. Used for bounded score, coin and credit totals in the project datapath.

Parameters:
LIMIT, 7, saturation threshold for the total; legal range 1..7.

Ports:
clk  input  1  clock; all state updates on the falling edge, matching the codebase flip-flops.
reset_n  input  1  asynchronous, active-low reset.
clear  input  1  synchronous clear of the total and flags; sampled on the falling edge.
in_valid  input  1  producer has a beat on in_data.
in_data  input  3  unsigned increment, 0..7.
in_ready  output  1  block can accept a beat this cycle.
acc  output  3  registered running total.
full  output  1  level flag: total is saturated at LIMIT.
ovf  output  1  sticky flag: an accepted beat would have exceeded LIMIT.
done  output  1  one-cycle pulse on entry to FULL.
beats  output  3  count of accepted beats since the last clear, wrapping modulo 8.

Behaviour:
- Reset (reset_n=0, asynchronous, no clock needed):
  - acc=0, beats=0, full=0, ovf=0, done=0.
  - State=IDLE; in_ready=1 as soon as reset is asserted.
- States: IDLE (total 0, no beat accepted), RUN (at least one beat accepted, total < LIMIT), FULL (total = LIMIT).
- in_ready is combinational and equals (state != FULL). It does not depend on in_valid or clear.
- Accept happens when in_valid=1 and in_ready=1 at a falling clk edge.
- Sum is computed as a 4-bit value: sum = acc + in_data. The adder carry-out is bit 3.
- Update on accept:
  - If sum < LIMIT: acc<=sum[2:0]; state<=RUN.
  - If sum >= LIMIT: acc<=LIMIT; state<=FULL; full<=1; done<=1 for exactly one cycle.
  - If sum > LIMIT: additionally ovf<=1. ovf stays set until clear or reset.
  - beats<=beats+1, wrapping 7->0.
- in_data=0 accepted:
  - From IDLE, the state moves to RUN and acc stays 0.
  - If LIMIT is reached (only possible when acc=LIMIT), the sum >= LIMIT rule applies.
- Latency: acc, full and done reflect a beat after 1 falling edge. The ready stall takes effect at the first clock low phase after entering FULL.
- FULL state:
  - in_valid is ignored; acc, beats and ovf hold.
  - done=0 after the entry cycle.
  - Leaves FULL only on clear or reset.
- clear=1 at a falling edge:
  - acc<=0, beats<=0, full<=0, ovf<=0, done<=0; state<=IDLE.
  - Clear has priority over a simultaneous accept; that beat is dropped and not counted.
  - The producer sees in_ready=1 during the clear cycle unless the block is in FULL, so the producer must not treat the beat as taken.
- Reset mid-operation:
  - Asserting reset_n at any phase forces reset values immediately.
  - Deasserting reset_n between edges leaves the block in IDLE; the first accept can occur at the next falling edge.
- Idle hold: in_valid=0 with clear=0 leaves all registers unchanged. done is deasserted.
- LIMIT=7 boundary: sum 7 -> FULL without ovf; sums 8..14 -> FULL with ovf. Detection uses the carry-out or sum[2:0]==7.
- No rising-edge behaviour: state must not change on a rising clk edge.

Test Plan:
1. Reset, then accept beats 2, 3 (LIMIT=7) -> acc 2 then 5; state RUN; full=0; beats=2; in_ready stays 1.
2. From acc=5, accept 2 -> acc=7, full=1, done pulses one cycle, ovf=0, in_ready=0. Holding in_valid=1 with data 4 for 3 cycles -> acc=7, beats=3 unchanged.
3. From acc=6, accept 5 (sum 11) -> acc=7, full=1, ovf=1, done pulse. Then clear -> acc=0, ovf=0, full=0, beats=0, in_ready=1.
4. Simultaneous clear=1 and in_valid=1 with data 3 at acc=4 -> acc=0, beats=0; the beat is not counted.
5. Build LIMIT=4, accept 1 four times -> acc 1,2,3,4; FULL on the fourth beat; done once. Then 8 more beats after clear with data 0 -> beats wraps 7->0, acc=0.
6. Assert reset_n=0 mid-clock-high while in RUN with acc=3 -> acc=0 and flags 0 immediately, without a clock edge. Release, accept 6 -> acc=6 at the next falling edge.
